// File: rtl/rf_thread_bank.sv
// Four-thread register file bank: one 8 x DATA_WIDTH file per thread, shared write port,
// two registered read ports for the decoding thread, and a post-reset zero-fill sequencer.
module rf_thread_bank #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            thread_ID,
  input  logic [ADDR_WIDTH-1:0] raddr0,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  RF0_WRE_WB,
  input  logic                  RF1_WRE_WB,
  input  logic                  RF2_WRE_WB,
  input  logic                  RF3_WRE_WB,
  output logic                  rf_ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NUM_THREADS = 4;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   clr_cnt_reg, clr_cnt_next;
  logic [DATA_WIDTH-1:0]   rdata0_reg, rdata0_next;
  logic [DATA_WIDTH-1:0]   rdata1_reg, rdata1_next;

  logic [NUM_THREADS-1:0]  wre;
  logic [NUM_THREADS-1:0]  bank_we;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   bank_rd0 [NUM_THREADS];
  logic [DATA_WIDTH-1:0]   bank_rd1 [NUM_THREADS];

  assign wre = {RF3_WRE_WB, RF2_WRE_WB, RF1_WRE_WB, RF0_WRE_WB};

  // One storage array per thread; all banks share the address/data of the write port.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (bank_we[gi]) begin
          mem[wr_addr] <= wr_data;
        end
      end

      assign bank_rd0[gi] = mem[raddr0];
      assign bank_rd1[gi] = mem[raddr1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    bank_we      = '0;
    wr_addr      = waddr;
    wr_data      = wdata;
    rdata0_next  = '0;
    rdata1_next  = '0;
    case (state_reg)
      CLEAR: begin
        // Zero the same index in every bank at once; demux writes are discarded here.
        bank_we      = '1;
        wr_addr      = clr_cnt_reg;
        wr_data      = '0;
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == ADDR_WIDTH'(DEPTH - 1)) begin
          state_next = READY;
        end
      end
      READY: begin
        bank_we     = wre;
        // Write-first: a same-cycle write to the decoding thread wins over the array contents.
        rdata0_next = (wre[thread_ID] && (waddr == raddr0)) ? wdata : bank_rd0[thread_ID];
        rdata1_next = (wre[thread_ID] && (waddr == raddr1)) ? wdata : bank_rd1[thread_ID];
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
    if (reset) begin
      bank_we = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0_reg <= '0;
      rdata1_reg <= '0;
    end else begin
      rdata0_reg <= rdata0_next;
      rdata1_reg <= rdata1_next;
    end
  end

  assign rdata0   = rdata0_reg;
  assign rdata1   = rdata1_reg;
  assign rf_ready = (state_reg == READY);

endmodule

// File: tb/tb_rf_thread_bank.sv
// Bench for rf_thread_bank: directed scenarios with literal expectations plus a randomized
// phase, all outputs compared every cycle against a behavioural register-file model.
module tb_rf_thread_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  thread_ID;
  logic [2:0]  raddr0, raddr1, waddr;
  logic [63:0] wdata;
  logic [63:0] rdata0, rdata1;
  logic [3:0]  we;
  logic        rf_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_thread_bank #(.DATA_WIDTH(64), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .thread_ID(thread_ID),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1),
    .waddr(waddr), .wdata(wdata),
    .RF0_WRE_WB(we[0]), .RF1_WRE_WB(we[1]), .RF2_WRE_WB(we[2]), .RF3_WRE_WB(we[3]),
    .rf_ready(rf_ready)
  );

  // Behavioural model: the file reads as all-zero once 8 reset-free edges have elapsed
  // since the last reset; until then outputs are zero and writes are ignored.
  logic [63:0] model [4][8];
  int          edges_since_reset = 0;
  bit          started = 0;
  logic [63:0] exp_r0 = '0, exp_r1 = '0;
  bit          exp_ready = 0;

  always @(posedge clk) begin
    if (reset) begin
      started           = 1;
      edges_since_reset = 0;
      exp_r0            = '0;
      exp_r1            = '0;
    end else if (edges_since_reset < 8) begin
      edges_since_reset++;
      exp_r0 = '0;
      exp_r1 = '0;
      if (edges_since_reset == 8) begin
        for (int t = 0; t < 4; t++)
          for (int a = 0; a < 8; a++)
            model[t][a] = '0;
      end
    end else begin
      exp_r0 = (we[thread_ID] && waddr == raddr0) ? wdata : model[thread_ID][raddr0];
      exp_r1 = (we[thread_ID] && waddr == raddr1) ? wdata : model[thread_ID][raddr1];
      for (int t = 0; t < 4; t++)
        if (we[t]) model[t][waddr] = wdata;
    end
    exp_ready = started && (edges_since_reset >= 8);
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_rf_ready", {63'd0, rf_ready}, {63'd0, exp_ready});
      chk("model_rdata0", rdata0, exp_r0);
      chk("model_rdata1", rdata1, exp_r1);
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input bit [1:0] tid, input bit [2:0] a0, input bit [2:0] a1,
                       input bit [2:0] wa, input logic [63:0] wd, input bit [3:0] w);
    reset = r; thread_ID = tid; raddr0 = a0; raddr1 = a1; waddr = wa; wdata = wd; we = w;
  endtask

  // One-cycle read of thread tid, address a on both ports, then literal comparison.
  task automatic read_chk(input string nm, input bit [1:0] tid, input bit [2:0] a, input logic [63:0] exp);
    drive(0, tid, a, a, 3'd0, 64'd0, 4'b0000);
    tick();
    $display("read  t%0d a%0d -> %h / %h", tid, a, rdata0, rdata1);
    chk(nm, rdata0, exp);
    chk(nm, rdata1, exp);
  endtask

  task automatic write1(input bit [3:0] w, input bit [2:0] wa, input logic [63:0] wd);
    drive(0, 2'd0, 3'd0, 3'd0, wa, wd, w);
    tick();
    $display("write en=%b a%0d <- %h", w, wa, wd);
  endtask

  task automatic clear_phase(input string nm, input bit drop_write);
    for (int i = 0; i < 8; i++) begin
      if (drop_write && i == 2) drive(0, 2'd0, 3'd7, 3'd7, 3'd7, 64'h1234, 4'b0001);
      else                      drive(0, 2'd0, 3'd0, 3'd0, 3'd0, 64'd0, 4'b0000);
      tick();
      $display("clear edge %0d rf_ready=%0b", i + 1, rf_ready);
      chk(nm, {63'd0, rf_ready}, (i == 7) ? 64'd1 : 64'd0);
    end
  endtask

  initial begin
    drive(1, 2'd0, 3'd0, 3'd0, 3'd0, 64'd0, 4'b0000);
    tick(); tick();
    chk("reset_ready", {63'd0, rf_ready}, 64'd0);
    chk("reset_rdata0", rdata0, 64'd0);
    chk("reset_rdata1", rdata1, 64'd0);
    clear_phase("first_clear_ready", 0);

    // Preload garbage, then reset and clear with a write dropped during the clear.
    for (int t = 0; t < 4; t++)
      for (int a = 0; a < 8; a++)
        write1(4'(1 << t), 3'(a), {$urandom, $urandom} | 64'd1);
    drive(1, 2'd0, 3'd0, 3'd0, 3'd0, 64'd0, 4'b0000);
    tick();
    chk("reclear_ready_low", {63'd0, rf_ready}, 64'd0);
    clear_phase("reclear_ready", 1);
    for (int t = 0; t < 4; t++)
      for (int a = 0; a < 8; a++)
        read_chk("cleared_entry", 2'(t), 3'(a), 64'd0);

    // Per-thread isolation.
    write1(4'b0010, 3'd1, 64'd2);
    read_chk("iso_t1", 2'd1, 3'd1, 64'd2);
    read_chk("iso_t0", 2'd0, 3'd1, 64'd0);
    read_chk("iso_t2", 2'd2, 3'd1, 64'd0);
    read_chk("iso_t3", 2'd3, 3'd1, 64'd0);

    // Same-cycle bypass on both ports, then a write to another thread.
    drive(0, 2'd2, 3'd5, 3'd5, 3'd5, 64'hDEAD_BEEF, 4'b0100);
    tick();
    chk("bypass_r0", rdata0, 64'hDEAD_BEEF);
    chk("bypass_r1", rdata1, 64'hDEAD_BEEF);
    drive(0, 2'd3, 3'd5, 3'd5, 3'd5, 64'hDEAD_BEEF, 4'b0100);
    tick();
    chk("other_thread_r0", rdata0, 64'd0);
    chk("other_thread_r1", rdata1, 64'd0);
    read_chk("bypass_landed", 2'd2, 3'd5, 64'hDEAD_BEEF);

    // Demux sweep then all enables at once; index 0 is writable too.
    for (int t = 0; t < 4; t++) write1(4'(1 << t), 3'd1, 64'd2);
    for (int t = 0; t < 4; t++) read_chk("sweep", 2'(t), 3'd1, 64'd2);
    write1(4'b1111, 3'd1, 64'hFF);
    for (int t = 0; t < 4; t++) read_chk("multi_en", 2'(t), 3'd1, 64'hFF);
    write1(4'b0001, 3'd0, 64'h77);
    read_chk("reg0_writable", 2'd0, 3'd0, 64'h77);

    // Reset mid-operation.
    write1(4'b1000, 3'd4, 64'hA5);
    read_chk("pre_reset_t3a4", 2'd3, 3'd4, 64'hA5);
    drive(1, 2'd3, 3'd4, 3'd4, 3'd0, 64'd0, 4'b0000);
    tick();
    chk("midreset_ready_low", {63'd0, rf_ready}, 64'd0);
    clear_phase("midreset_clear", 0);
    read_chk("midreset_t3a4", 2'd3, 3'd4, 64'd0);

    // Randomized traffic, occasional resets; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0), 2'($urandom), 3'($urandom), 3'($urandom),
            3'($urandom), {$urandom, $urandom}, ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_thread_bank.md
# rf_thread_bank

Four-thread register file bank sitting directly downstream of the writeback demultiplexer. Holds one 8-entry x 64-bit register file per hardware thread. Accepts the demux's shared write address/data and per-thread write enables. Serves two synchronous read ports for the thread currently in decode. After reset, a built-in clear sequencer zeroes every entry before the bank reports ready.

## Interface
Parameters:
- DATA_WIDTH, 64, register width in bits
- ADDR_WIDTH, 3, register index width (8 registers per thread)
- Thread count is fixed at 4; not parameterised.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- thread_ID  input  2  thread whose registers are read this cycle
- raddr0  input  ADDR_WIDTH  read port 0 register index
- raddr1  input  ADDR_WIDTH  read port 1 register index
- rdata0  output  DATA_WIDTH  registered read data, port 0
- rdata1  output  DATA_WIDTH  registered read data, port 1
- waddr  input  ADDR_WIDTH  write index from demux (waddr_DEMUX_out)
- wdata  input  DATA_WIDTH  write data from demux (wdata_DEMUX_out)
- RF0_WRE_WB..RF3_WRE_WB  input  1 each  per-thread write enables from demux
- rf_ready  output  1  high once post-reset clear is complete

## Operation
- Storage is 4 banks x 8 entries x DATA_WIDTH. Contents are undefined until cleared.
- FSM has two states: CLEAR and READY.
- **Reset:**
  - reset=1 forces state CLEAR, clear counter 0, rf_ready=0, rdata0=rdata1=0.
  - Reset asserted mid-operation, in either state, restarts the clear from index 0.
- **CLEAR:**
  - Each cycle with reset=0 writes 0 to entry clr_cnt in all four banks simultaneously, then increments clr_cnt.
  - After writing index 7, the FSM goes to READY and rf_ready=1.
  - CLEAR lasts exactly 8 cycles.
  - RFn_WRE_WB writes are dropped; no queueing.
  - rdata0/rdata1 are held at 0.
- **READY write:**
  - On each edge, for each n with RFn_WRE_WB=1, bank[n][waddr] <= wdata.
  - Multiple enables asserted together write the same address/data into each enabled bank. This is legal and not an error.
- **READY read:**
  - rdata0 <= bank[thread_ID][raddr0]; rdata1 <= bank[thread_ID][raddr1].
- **Write-first bypass:**
  - Applies when RF{thread_ID}_WRE_WB=1 and waddr==raddrX in the same cycle.
  - rdataX then captures wdata, not the stale array value.
  - The bypass applies to each port independently, including when both ports hit the same address.
- A write to a thread other than thread_ID never affects that cycle's rdata.
- All 8 registers, including index 0, are writable. There is no hardwired zero register.
- READY persists until the next reset.

## Timing
- Read latency is 1 cycle: address and thread_ID presented before edge k produce rdata valid after edge k.
- Write latency is 1 cycle. A read issued in the cycle after the write edge sees the new value via the array. A read issued in the same cycle as the write sees it via the bypass.
- rf_ready rises on the 8th rising edge with reset=0 after reset deassertion.
- The first legal write is the cycle rf_ready=1 is sampled high.
- rdata outputs are registered, with no combinational path from inputs to outputs. rf_ready is a registered flag.
- Reset values: rdata0=0, rdata1=0, rf_ready=0, FSM=CLEAR, clr_cnt=0.

## Test plan
- **Clear sequence:** Preload garbage via writes, assert reset 1 cycle, release. Required: rf_ready=0 for 8 edges, then 1. Reading all 32 entries (thread 0-3, addr 0-7) afterwards returns 0.
- **Per-thread isolation:** waddr=1, wdata=2, RF1_WRE_WB=1 only. Required: thread_ID=1 raddr0=1 returns 2 next cycle. Threads 0, 2 and 3 addr 1 return 0.
- **Same-cycle bypass:** thread_ID=2, raddr0=raddr1=5, RF2_WRE_WB=1, waddr=5, wdata=64'hDEAD_BEEF. Required: both rdata=64'hDEAD_BEEF after the edge. The same write with thread_ID=3 returns the old thread-3 value (0).
- **Writes during CLEAR dropped:** Release reset, assert RF0_WRE_WB with waddr=7 and wdata=64'h1234 at cycle 3. Required: after rf_ready, thread 0 addr 7 reads 0.
- **Reset mid-operation:** Write 64'hA5 to thread 3 addr 4, let rf_ready=1, assert reset for 1 cycle. Required: rf_ready drops to 0, the 8-cycle clear repeats, and thread 3 addr 4 reads 0.
- **Multi-enable and demux sweep:** With WRE=1, sweep thread_WB 0 to 3 through the upstream demux with waddr=1 and wdata=2. Then force all four enables high with wdata=64'hFF. Required: each thread addr 1 reads 2 after the sweep, then 64'hFF after the forced write.
